// File: rtl/reg_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reg_reader: reads len+1 registers from base 8 (up/down) and sums them.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module reg_reader (
  input  logic        clock,
  input  logic        reset,
  input  logic        go,
  input  logic        direction,
  input  logic [2:0]  len,
  input  logic [31:0] data,
  output logic [4:0]  regnum,
  output logic        rd_en,
  output logic [31:0] sum,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [4:0] BASE_REG = 5'd8;

  state_t     state;
  logic [2:0] idx;
  logic [2:0] len_q;
  logic       dir_q;
  logic [2:0] idx_next;
  logic [4:0] next_reg;

  // Outputs are registered, so the register for the following READ cycle is
  // computed one step ahead from the incremented index.
  assign idx_next = idx + 3'd1;
  assign next_reg = dir_q ? (BASE_REG + {2'b00, idx_next})
                          : (BASE_REG - {2'b00, idx_next});

  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      idx    <= 3'd0;
      len_q  <= 3'd0;
      dir_q  <= 1'b0;
      regnum <= 5'd0;
      rd_en  <= 1'b0;
      sum    <= 32'd0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            state  <= ARM;
            regnum <= BASE_REG;
            sum    <= 32'd0;
          end
        end
        ARM: begin
          if (!go) begin
            state  <= READ;
            dir_q  <= direction;
            len_q  <= len;
            idx    <= 3'd0;
            regnum <= BASE_REG;
            rd_en  <= 1'b1;
          end
        end
        READ: begin
          sum <= sum + data;
          if (idx == len_q) begin
            state  <= DONE;
            regnum <= 5'd0;
            rd_en  <= 1'b0;
            done   <= 1'b1;
          end else begin
            idx    <= idx_next;
            regnum <= next_reg;
          end
        end
        DONE: begin
          if (go) begin
            state  <= ARM;
            regnum <= BASE_REG;
            sum    <= 32'd0;
            done   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_reg_reader: randomized bench with a burst-queue reference model.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_reg_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        go = 1'b0;
  logic        direction = 1'b0;
  logic [2:0]  len = 3'd0;
  logic [31:0] data;
  logic [4:0]  regnum;
  logic        rd_en;
  logic [31:0] sum;
  logic        done;

  logic        force_ones = 1'b0;
  logic        checking = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  reg_reader dut (
    .clock    (clock),
    .reset    (reset),
    .go       (go),
    .direction(direction),
    .len      (len),
    .data     (data),
    .regnum   (regnum),
    .rd_en    (rd_en),
    .sum      (sum),
    .done     (done)
  );

  always #5 clock = ~clock;

  // Register file: each register holds 16 times its number.
  always_comb data = force_ones ? 32'hFFFF_FFFF : {23'd0, regnum, 4'd0};

  // Reference: idle / armed / reading a planned burst of registers / finished.
  int          mode = 0;
  int          plan[$];
  logic [31:0] m_sum = 32'd0;

  always @(posedge clock) begin
    if (!reset) begin
      mode  = 0;
      plan.delete();
      m_sum = 32'd0;
    end else begin
      case (mode)
        0, 3: if (go) begin mode = 1; m_sum = 32'd0; end
        1: if (!go) begin
          plan.delete();
          for (int n = 0; n <= int'(len); n++) plan.push_back(direction ? 8 + n : 8 - n);
          mode = 2;
        end
        2: begin
          m_sum = m_sum + (force_ones ? 32'hFFFF_FFFF : 32'(16 * plan[0]));
          void'(plan.pop_front());
          if (plan.size() == 0) mode = 3;
        end
        default: mode = 0;
      endcase
    end
  end

  function automatic logic [4:0] exp_regnum();
    if (mode == 1) return 5'd8;
    if (mode == 2) return 5'(plan[0]);
    return 5'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clock) begin
    if (checking) begin
      check("regnum", {27'd0, regnum}, {27'd0, exp_regnum()});
      check("rd_en", {31'd0, rd_en}, {31'd0, mode == 2});
      check("done", {31'd0, done}, {31'd0, mode == 3});
      check("sum", sum, m_sum);
      check("done_rd_en_exclusive", {31'd0, done & rd_en}, 32'd0);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Arm for `hold` cycles, release go, then disturb the controls mid-READ.
  task automatic launch(input logic dir, input logic [2:0] l, input int hold, input logic flip);
    direction = dir;
    len       = l;
    go        = 1'b1;
    repeat (hold) step();
    go = 1'b0;
    step();
    direction = flip ? ~dir : 1'($urandom);
    len       = 3'($urandom);
    go        = 1'($urandom);
    step();
    go = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic use_lit, input logic [31:0] lit);
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (done !== 1'b1) begin
      check({name, "_timeout"}, {31'd0, done}, 32'd1);
    end else if (use_lit) begin
      check({name, "_dut_sum"}, sum, lit);
      check({name, "_model_sum"}, m_sum, lit);
    end
    step();
  endtask

  initial begin
    repeat (3) step();
    checking = 1'b1;
    check("reset_sum", sum, 32'd0);
    check("reset_regnum", {27'd0, regnum}, 32'd0);
    reset = 1'b1;
    step();

    launch(1'b1, 3'd4, 1, 1'b0);  wait_done("ascend", 1'b1, 32'd800);
    launch(1'b0, 3'd4, 1, 1'b0);  wait_done("descend", 1'b1, 32'd480);
    launch(1'b1, 3'd0, 3, 1'b0);  wait_done("len0_hold3", 1'b1, 32'd128);
    force_ones = 1'b1;
    launch(1'b1, 3'd1, 1, 1'b0);  wait_done("wrap", 1'b1, 32'hFFFF_FFFE);
    force_ones = 1'b0;

    // Reset lands during the third READ cycle.
    direction = 1'b1; len = 3'd6; go = 1'b1;
    step();
    go = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("midreset_sum", sum, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_regnum", {27'd0, regnum}, 32'd0);
    launch(1'b1, 3'd2, 1, 1'b0);  wait_done("after_reset", 1'b1, 32'd432);

    // Restart from DONE with direction flipped once reading has begun.
    launch(1'b0, 3'd3, 1, 1'b1);  wait_done("restart_flip", 1'b1, 32'd416);

    for (int r = 0; r < 25; r++) begin
      force_ones = ($urandom_range(0, 5) == 0);
      launch(1'($urandom), 3'($urandom), $urandom_range(1, 3), 1'($urandom));
      wait_done("random", 1'b0, 32'd0);
      repeat ($urandom_range(0, 2)) step();
      force_ones = 1'b0;
    end

    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
